// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF response collector.
package puf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/puf_majority_sampler.sv
// Counts ones over VOTES enabled cycles and reports the majority and stability of one bit.
module puf_majority_sampler
  import puf_pkg::*;
#(
  parameter int VOTES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic maj,
  output logic unstable,
  output logic last
);

  localparam int VW = clog2(VOTES + 1);

  logic [VW-1:0] ones;
  logic [VW-1:0] idx;
  logic [VW-1:0] ones_nxt;

  // maj/unstable include the sample taken on the strobe cycle itself
  assign ones_nxt = ones + VW'(din);
  assign last     = en && (idx == VW'(VOTES - 1));
  assign maj      = ones_nxt > VW'(VOTES / 2);
  assign unstable = (ones_nxt != '0) && (ones_nxt != VW'(VOTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= '0;
      idx  <= '0;
    end else if (clr || last) begin
      ones <= '0;
      idx  <= '0;
    end else if (en) begin
      ones <= ones_nxt;
      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// Sequences LFSR challenges into an arbiter PUF, majority-votes each response bit
// and returns a packed word plus unstable-bit count over a valid/ready handshake.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int             N      = 32,
  parameter logic [N-1:0]   TAPS   = N'(DEFAULT_TAPS),
  parameter int             RESP_W = 32,
  parameter int             SETTLE = 4,
  parameter int             VOTES  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N-1:0]                 seed,
  output logic [N-1:0]                 challenge_out,
  input  logic                         resp_bit,
  output logic                         busy,
  output logic [RESP_W-1:0]            resp_word,
  output logic [clog2(RESP_W+1)-1:0]   unstable_cnt,
  output logic                         resp_valid,
  input  logic                         resp_ready
);

  localparam int SW = clog2(SETTLE + 1);
  localparam int BW = clog2(RESP_W + 1);
  localparam int UW = clog2(RESP_W + 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] settle_cnt;
  logic [BW-1:0] bit_idx;
  logic          accept;
  logic          settle_end;
  logic          last_bit;
  logic          maj;
  logic          unstable;
  logic          last;

  assign accept     = (state == ST_IDLE) && start;
  assign settle_end = (settle_cnt == SW'(SETTLE - 1));
  assign last_bit   = (bit_idx == BW'(RESP_W - 1));
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_DONE);

  puf_majority_sampler #(.VOTES(VOTES)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state == ST_SAMPLE),
    .din      (resp_bit),
    .maj      (maj),
    .unstable (unstable),
    .last     (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_end) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (last) state_nxt = last_bit ? ST_DONE : ST_SETTLE;
      ST_DONE:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // A zero seed would lock the LFSR at zero, so it is replaced with 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      challenge_out <= '0;
      resp_word     <= '0;
      unstable_cnt  <= '0;
      settle_cnt    <= '0;
      bit_idx       <= '0;
    end else if (accept) begin
      challenge_out <= (seed == '0) ? N'(1) : seed;
      resp_word     <= '0;
      unstable_cnt  <= '0;
      settle_cnt    <= '0;
      bit_idx       <= '0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_end ? '0 : settle_cnt + 1'b1;
    end else if ((state == ST_SAMPLE) && last) begin
      resp_word     <= {resp_word[RESP_W-2:0], maj};
      unstable_cnt  <= unstable_cnt + UW'(unstable);
      challenge_out <= {challenge_out[N-2:0], ^(challenge_out & TAPS)};
      if (!last_bit) bit_idx <= bit_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboard bench for puf_response_collector with a behavioural arbiter-PUF model.
module tb_puf_response_collector;

  localparam int          RESP_W  = 32;
  localparam int          VOTES   = 5;
  localparam int          PERIOD  = 9;               // SETTLE + VOTES
  localparam int          LATENCY = RESP_W * PERIOD; // 288
  localparam logic [31:0] TAPS    = 32'h80200003;

  localparam int M_ONE  = 0;
  localparam int M_PAR  = 1;
  localparam int M_K    = 2;
  localparam int M_RAND = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic [31:0] challenge_out;
  logic        resp_bit;
  logic        busy;
  logic [31:0] resp_word;
  logic [5:0]  unstable_cnt;
  logic        resp_valid;
  logic        resp_ready;

  typedef struct {
    logic [31:0] word;
    int          ucnt;
    logic [31:0] chal;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks;
  int          failures;
  int          cyc;
  logic        prev_valid;
  logic        samp[RESP_W][VOTES];
  logic [31:0] gch[RESP_W+1];

  puf_response_collector dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .seed          (seed),
    .challenge_out (challenge_out),
    .resp_bit      (resp_bit),
    .busy          (busy),
    .resp_word     (resp_word),
    .unstable_cnt  (unstable_cnt),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {x[30:0], ^(x & TAPS)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: every rising resp_valid must match the oldest expected word
  always @(negedge clk) begin
    if (resp_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid got=1 expected=0");
      end else begin
        mon_e = sb.pop_front();
        check("mon_word", resp_word, mon_e.word);
        check("mon_unstable", unstable_cnt, mon_e.ucnt);
        check("mon_challenge", challenge_out, mon_e.chal);
        check("mon_latency", cyc - mon_e.t0, LATENCY);
      end
    end
    prev_valid = resp_valid;
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_challenge"}, challenge_out, 0);
    check({tag, "_word"}, resp_word, 0);
    check({tag, "_unstable"}, unstable_cnt, 0);
    check({tag, "_valid"}, resp_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Called at a falling edge; drives a full collection run (or aborts it with rst)
  task automatic run(input int mode, input int k, input logic [31:0] sd,
                     input int hold, input int abort_at);
    exp_t        e;
    logic [31:0] ch;
    int          ones;
    logic        s;
    int          b;
    int          p;
    ch     = (sd == 0) ? 32'd1 : sd;
    gch[0] = ch;
    e.word = '0;
    e.ucnt = 0;
    for (int bi = 0; bi < RESP_W; bi++) begin
      ones = 0;
      for (int v = 0; v < VOTES; v++) begin
        case (mode)
          M_ONE:   s = 1'b1;
          M_PAR:   s = ^ch;
          M_K:     s = (v < k);
          default: s = 1'($urandom % 2);
        endcase
        samp[bi][v] = s;
        ones += int'(s);
      end
      e.word = {e.word[30:0], (ones > VOTES / 2)};
      if (ones != 0 && ones != VOTES) e.ucnt++;
      ch          = lfsr_step(ch);
      gch[bi + 1] = ch;
    end
    e.chal     = ch;
    resp_ready = (hold == 0);
    start      = 1'b1;
    seed       = sd;
    @(posedge clk);
    @(negedge clk);
    seed = $urandom;
    e.t0 = cyc;
    if (abort_at < 0) sb.push_back(e);
    check("busy_after_start", busy, 1);
    for (int c = 0; c < LATENCY; c++) begin
      if (c == abort_at) begin
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check_zero_outputs("abort");
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("abort_held");
        rst = 1'b0;
        return;
      end
      if (c % PERIOD == 0) check("challenge", challenge_out, gch[c / PERIOD]);
      start = (mode == M_RAND) ? 1'($urandom % 2) : 1'b0;
      b = c / PERIOD;
      p = c % PERIOD;
      if (p >= PERIOD - VOTES)
        resp_bit = (mode == M_PAR) ? ^challenge_out : samp[b][p - (PERIOD - VOTES)];
      else
        resp_bit = 1'($urandom % 2);
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    check("final_challenge", challenge_out, e.chal);
    check("valid_at_latency", resp_valid, 1);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", resp_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_word", resp_word, e.word);
      check("hold_unstable", unstable_cnt, e.ucnt);
      check("hold_challenge", challenge_out, e.chal);
      start    = 1'b1;
      seed     = $urandom;
      resp_bit = 1'($urandom % 2);
      @(posedge clk);
      @(negedge clk);
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_handshake_valid", resp_valid, 0);
    check("post_handshake_busy", busy, 0);
    check("retained_word", resp_word, e.word);
    check("retained_unstable", unstable_cnt, e.ucnt);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    prev_valid = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    resp_bit   = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run(M_ONE, 0, 32'd1, 0, -1);
    run(M_PAR, 0, 32'd0, 0, -1);
    run(M_PAR, 0, 32'hACE1, 0, -1);
    run(M_K, 2, $urandom, 0, -1);
    run(M_K, 4, $urandom, 0, -1);
    run(M_RAND, 0, $urandom, 10, -1);
    run(M_PAR, 0, $urandom, 0, 7 * PERIOD + 6);
    run(M_PAR, 0, $urandom, 0, -1);
    for (int i = 0; i < 3; i++) run(M_RAND, 0, $urandom, i, -1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
